// File: rtl/keypad_entry_pkg.sv
// Shared key codes, state encodings and the saturating calculator helper
// for the keypad entry block.
package keypad_entry_pkg;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_CLR = 4'hC;
   localparam logic [3:0] KEY_EQ  = 4'hE;

   typedef enum logic [1:0] {ENTER_A, ENTER_B, RESULT} entry_state_t;
   typedef enum logic       {UP, DOWN}                 db_state_t;

   // 17-bit intermediate so chained results clamp instead of wrapping
   function automatic logic signed [15:0] calc(input logic signed [15:0] x,
                                               input logic signed [15:0] y,
                                               input logic sub);
      logic signed [16:0] s;
      s = sub ? ({x[15], x} - {y[15], y}) : ({x[15], x} + {y[15], y});
      if (s > 17'sd32767)       return 16'sh7FFF;
      else if (s < -17'sd32768) return 16'sh8000;
      else                      return s[15:0];
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Row synchronizer plus UP/DOWN debounce FSM; emits one key event per press,
// tolerating the short inactive gaps of the column scan.
module key_debounce
   import keypad_entry_pkg::*;
#(
   parameter int PRESS_CYCLES   = 1000000,
   parameter int RELEASE_CYCLES = 500000,
   parameter int CW             = 20
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    row,
   input  logic [3:0]    key_code,
   output logic          key_valid,
   output logic [3:0]    key_out
);

   logic [3:0]    row_s1, row_s2;
   logic          active;
   db_state_t     state, state_nx;
   logic [CW-1:0] press_cnt, press_nx;
   logic [CW-1:0] gap_cnt, gap_nx;
   logic          fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1 <= 4'b1111;
         row_s2 <= 4'b1111;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
      end
   end

   assign active = (row_s2 != 4'b1111);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= UP;
         press_cnt <= '0;
         gap_cnt   <= '0;
         key_valid <= 1'b0;
         key_out   <= 4'h0;
      end else begin
         state     <= state_nx;
         press_cnt <= press_nx;
         gap_cnt   <= gap_nx;
         key_valid <= fire;
         if (fire) key_out <= key_code;
      end
   end

   always_comb begin
      state_nx = state;
      press_nx = press_cnt;
      gap_nx   = gap_cnt;
      fire     = 1'b0;
      case (state)
         UP: begin
            if (active) begin
               gap_nx = '0;
               if (press_cnt == CW'(PRESS_CYCLES - 1)) begin
                  fire     = 1'b1;
                  press_nx = '0;
                  state_nx = DOWN;
               end else begin
                  press_nx = press_cnt + 1'b1;
               end
            end else begin
               // gap counter saturates; a long gap abandons a partial press
               if (gap_cnt < CW'(RELEASE_CYCLES)) gap_nx = gap_cnt + 1'b1;
               if (gap_cnt >= CW'(RELEASE_CYCLES - 1)) press_nx = '0;
            end
         end
         DOWN: begin
            if (active) begin
               gap_nx = '0;
            end else if (gap_cnt == CW'(RELEASE_CYCLES - 1)) begin
               gap_nx   = '0;
               press_nx = '0;
               state_nx = UP;
            end else begin
               gap_nx = gap_cnt + 1'b1;
            end
         end
         default: state_nx = UP;
      endcase
   end

endmodule

// File: rtl/keypad_entry.sv
// Calculator entry front end: debounced key events drive an A-op-B-equals
// FSM producing a signed display value and a result strobe.
module keypad_entry
   import keypad_entry_pkg::*;
#(
   parameter int PRESS_CYCLES   = 1000000,
   parameter int RELEASE_CYCLES = 500000,
   parameter int MAX_DIGITS     = 4,
   parameter int CW             = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         row,
   input  logic [3:0]         key_code,
   output logic               key_valid,
   output logic [3:0]         key_out,
   output logic signed [15:0] display_val,
   output logic               result_valid,
   output logic               op_pending
);

   entry_state_t       st, st_nx;
   logic signed [15:0] a, a_nx, b, b_nx, res, res_nx;
   logic [3:0]         a_cnt, a_cnt_nx, b_cnt, b_cnt_nx;
   logic               sub, sub_nx, rv_nx;
   logic               is_digit, is_op;
   logic signed [15:0] dval;

   key_debounce #(
      .PRESS_CYCLES  (PRESS_CYCLES),
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .CW            (CW)
   ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .row      (row),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_out  (key_out)
   );

   assign is_digit = (key_out <= 4'd9);
   assign is_op    = (key_out == KEY_ADD) || (key_out == KEY_SUB);
   assign dval     = {12'h000, key_out};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= ENTER_A;
         a            <= '0;
         b            <= '0;
         res          <= '0;
         a_cnt        <= '0;
         b_cnt        <= '0;
         sub          <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         st           <= st_nx;
         a            <= a_nx;
         b            <= b_nx;
         res          <= res_nx;
         a_cnt        <= a_cnt_nx;
         b_cnt        <= b_cnt_nx;
         sub          <= sub_nx;
         result_valid <= rv_nx;
      end
   end

   always_comb begin
      st_nx    = st;
      a_nx     = a;
      b_nx     = b;
      res_nx   = res;
      a_cnt_nx = a_cnt;
      b_cnt_nx = b_cnt;
      sub_nx   = sub;
      rv_nx    = 1'b0;
      if (key_valid) begin
         if (key_out == KEY_CLR) begin
            st_nx    = ENTER_A;
            a_nx     = '0;
            b_nx     = '0;
            res_nx   = '0;
            a_cnt_nx = '0;
            b_cnt_nx = '0;
            sub_nx   = 1'b0;
         end else begin
            case (st)
               ENTER_A: begin
                  if (is_digit && a_cnt < 4'(MAX_DIGITS)) begin
                     a_nx     = (a <<< 3) + (a <<< 1) + dval;
                     a_cnt_nx = a_cnt + 1'b1;
                  end else if (is_op) begin
                     sub_nx   = (key_out == KEY_SUB);
                     b_nx     = '0;
                     b_cnt_nx = '0;
                     st_nx    = ENTER_B;
                  end
               end
               ENTER_B: begin
                  if (is_digit && b_cnt < 4'(MAX_DIGITS)) begin
                     b_nx     = (b <<< 3) + (b <<< 1) + dval;
                     b_cnt_nx = b_cnt + 1'b1;
                  end else if (is_op) begin
                     sub_nx = (key_out == KEY_SUB);
                  end else if (key_out == KEY_EQ) begin
                     res_nx = calc(a, b, sub);
                     rv_nx  = 1'b1;
                     st_nx  = RESULT;
                  end
               end
               RESULT: begin
                  if (is_op) begin
                     // chained A is a result, so lock out further A digits
                     a_nx     = res;
                     a_cnt_nx = 4'(MAX_DIGITS);
                     sub_nx   = (key_out == KEY_SUB);
                     b_nx     = '0;
                     b_cnt_nx = '0;
                     st_nx    = ENTER_B;
                  end else if (is_digit) begin
                     a_nx     = dval;
                     a_cnt_nx = 4'd1;
                     b_nx     = '0;
                     b_cnt_nx = '0;
                     st_nx    = ENTER_A;
                  end else if (key_out == KEY_EQ) begin
                     a_nx   = res;
                     res_nx = calc(res, b, sub);
                     rv_nx  = 1'b1;
                  end
               end
               default: st_nx = ENTER_A;
            endcase
         end
      end
   end

   always_comb begin
      case (st)
         ENTER_B: display_val = (b_cnt != 4'd0) ? b : a;
         RESULT:  display_val = res;
         default: display_val = a;
      endcase
   end

   assign op_pending = (st == ENTER_B);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with short debounce thresholds and a
// 4-low/6-high row pattern standing in for the column scan.
module tb_keypad_entry;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [3:0]         row;
   logic [3:0]         key_code;
   logic               key_valid;
   logic [3:0]         key_out;
   logic signed [15:0] display_val;
   logic               result_valid;
   logic               op_pending;

   int checks = 0;
   int errors = 0;
   int kv_cnt = 0;
   int rv_cnt = 0;
   int k0;

   keypad_entry #(
      .PRESS_CYCLES  (8),
      .RELEASE_CYCLES(20),
      .MAX_DIGITS    (4),
      .CW            (20)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row         (row),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_out     (key_out),
      .display_val (display_val),
      .result_valid(result_valid),
      .op_pending  (op_pending)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid)    kv_cnt++;
      if (result_valid) rv_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scan_period();
      row = 4'b1011;
      idle(4);
      row = 4'b1111;
      idle(6);
   endtask

   // one full press: three scan periods held, then a release longer than the threshold
   task automatic press(input logic [3:0] code, input int exp_disp, input string tag);
      int k;
      k = kv_cnt;
      key_code = code;
      repeat (3) scan_period();
      idle(30);
      chk({tag, "_kv"}, kv_cnt - k, 1);
      chk({tag, "_disp"}, int'(display_val), exp_disp);
   endtask

   initial begin
      rst_n    = 1'b0;
      row      = 4'b1111;
      key_code = 4'h0;
      idle(3);
      chk("rst_kv",   int'(key_valid), 0);
      chk("rst_kout", int'(key_out), 0);
      chk("rst_disp", int'(display_val), 0);
      chk("rst_rv",   int'(result_valid), 0);
      chk("rst_op",   int'(op_pending), 0);
      rst_n = 1'b1;
      idle(3);

      // long hold: one event only
      key_code = 4'd5;
      repeat (20) scan_period();
      chk("hold_kv", kv_cnt, 1);
      idle(30);
      chk("hold_kv_after_rel", kv_cnt, 1);
      chk("hold_kout", int'(key_out), 5);
      chk("hold_disp", int'(display_val), 5);

      // short bursts separated by long gaps never qualify
      k0 = kv_cnt;
      key_code = 4'd7;
      row = 4'b1110; idle(3); row = 4'b1111; idle(25);
      row = 4'b1110; idle(3); row = 4'b1111; idle(25);
      chk("burst_no_kv", kv_cnt - k0, 0);

      press(4'hC, 0, "clr0");
      press(4'd1, 1, "s1_1");
      press(4'd2, 12, "s1_2");
      press(4'hA, 12, "s1_add");
      chk("s1_op_pend", int'(op_pending), 1);
      press(4'd3, 3, "s1_3");
      press(4'd4, 34, "s1_4");
      press(4'hE, 46, "s1_eq");
      chk("s1_rv_cnt", rv_cnt, 1);
      chk("s1_op_end", int'(op_pending), 0);

      press(4'd7, 7, "s2_7");
      press(4'hB, 7, "s2_sub");
      press(4'd9, 9, "s2_9");
      press(4'hE, -2, "s2_eq");
      press(4'hE, -11, "s2_eq2");
      chk("s2_rv_cnt", rv_cnt, 3);

      press(4'hC, 0, "clr1");
      press(4'd1, 1, "s3_1");
      press(4'd2, 12, "s3_2");
      press(4'd3, 123, "s3_3");
      press(4'd4, 1234, "s3_4");
      press(4'd5, 1234, "s3_5_ignored");
      press(4'hC, 0, "s3_clr");
      chk("s3_op", int'(op_pending), 0);

      // reset in the middle of ENTER_B with a key held
      press(4'd1, 1, "s4_1");
      press(4'hA, 1, "s4_add");
      press(4'd3, 3, "s4_3");
      chk("s4_op_pend", int'(op_pending), 1);
      k0 = kv_cnt;
      key_code = 4'd6;
      row = 4'b0111; idle(4);
      row = 4'b1111; idle(6);
      row = 4'b0111; idle(3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_kv",   int'(key_valid), 0);
      chk("mid_rst_kout", int'(key_out), 0);
      chk("mid_rst_disp", int'(display_val), 0);
      chk("mid_rst_rv",   int'(result_valid), 0);
      chk("mid_rst_op",   int'(op_pending), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      row = 4'b1111; idle(6);
      row = 4'b0111; idle(4);
      row = 4'b1111; idle(6);
      chk("post_rst_no_early", kv_cnt - k0, 0);
      row = 4'b0111; idle(4);
      row = 4'b1111; idle(6);
      chk("post_rst_kv", kv_cnt - k0, 1);
      chk("post_rst_kout", int'(key_out), 6);
      chk("post_rst_disp", int'(display_val), 6);
      idle(30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Sits directly downstream of the keypad column-scan decoder.
- Consumes the decoder's held 4-bit key code plus the raw active-low Row lines.
- Debounces presses into single key events, then runs a calculator entry FSM: operand A, operator, operand B, equals.
- Drives a signed display value and a one-cycle result strobe to the display/ALU side.

Parameters:
- PRESS_CYCLES, 1000000, cycles of continuous row activity before a press is accepted (10 ms at 100 MHz).
- RELEASE_CYCLES, 500000, cycles with no row activity before release is declared. Must exceed one full decoder scan period of 400000 cycles.
- MAX_DIGITS, 4, maximum decimal digits per operand (operand max 9999).
- CW, 20, width of the debounce counters.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- row  in  4  raw keypad Row lines, active-low. Any bit 0 means row activity.
- key_code  in  4  decoder value: 0-9 digits, A=add, B=subtract, C=clear all, E=equals, D/F=ignored.
- key_valid  out  1  one-cycle strobe per accepted press.
- key_out  out  4  code latched at the press; held until the next press.
- display_val  out  16  signed two's complement: operand being entered, or result.
- result_valid  out  1  one-cycle strobe when a result is produced.
- op_pending  out  1  high while an operator is latched and B is not yet complete.

Behaviour:
- Reset (async, rst_n=0): all counters 0, debounce state UP, entry state ENTER_A, A=B=0, digit counts 0. key_valid=0, key_out=0, display_val=0, result_valid=0, op_pending=0.
- row is double-flopped before use. active = (row_sync != 4'b1111).
- Debounce FSM, state UP:
  - On active: increment press_cnt and clear gap_cnt.
  - On inactive: increment gap_cnt. When gap_cnt reaches RELEASE_CYCLES, press_cnt clears.
  - Inactive gaps shorter than RELEASE_CYCLES (normal scan gaps) do not reset press_cnt.
  - When press_cnt reaches PRESS_CYCLES: latch key_code into key_out, pulse key_valid for one cycle, go to DOWN.
- Debounce FSM, state DOWN:
  - gap_cnt counts inactive cycles and clears on active.
  - When gap_cnt reaches RELEASE_CYCLES: go to UP with counters cleared.
  - No further events while DOWN. A held key yields exactly one event.
- Counters saturate at their thresholds and never wrap.
- Entry FSM advances only on key_valid. Latency: the state and outputs update on the cycle after the key_valid strobe.
- ENTER_A:
  - Digit d: A = A*10 + d and the digit count increments. If the count is already MAX_DIGITS, the digit is ignored.
  - A or B key: latch the operator, op_pending=1, go to ENTER_B with B=0.
  - E: ignored.
  - display_val = A.
- ENTER_B:
  - Digit: same rules as A, applied to B. display_val = B once its first digit arrives; until then display_val stays at A.
  - A or B key: replaces the latched operator.
  - E: result = A+B or A-B computed in 16-bit signed. Go to RESULT, pulse result_valid, op_pending=0.
- RESULT:
  - display_val = result.
  - A or B key: A = result (chaining), go to ENTER_B. The A digit count is treated as full, so no further digits are appended to A.
  - Digit: start a new A = d with count 1, go to ENTER_A.
  - E: repeat the last operation with A = result and the same B. Pulse result_valid again.
- C in any state: return to reset values of the entry FSM. The debounce FSM is unaffected.
- Range: A and B are at most 9999. The result range -9999..19998 fits in 16-bit signed, so no overflow handling is needed. A chained result is at most 16-bit; A+B saturates at 32767 and A-B at -32768.
- key_code changing while DOWN has no effect.
- Reset asserted mid-press: everything clears asynchronously. After release of reset, a still-held key must accumulate a full PRESS_CYCLES before it counts.

Decomposition:
- Shared package: key code constants (KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_CLR=4'hC, KEY_EQ=4'hE), entry state encoding, debounce state encoding.
- One sub-module, key_debounce: the synchronizer plus the UP/DOWN FSM. It outputs key_valid and key_out.
- keypad_entry instantiates key_debounce and holds the entry FSM and datapath.

Test Plan (PRESS_CYCLES=8, RELEASE_CYCLES=20, row activity modelled as a 4-cycle low pulse every 10 cycles):
- Hold key 5 for 200 cycles, then release -> exactly one key_valid with key_out=5, and display_val=5. No second strobe after release.
- Activity bursts totalling 6 cycles, separated by 25-cycle gaps -> no key_valid.
- Keys 1,2,A,3,4,E -> display_val sequence 1, 12, 12, 3, 34, then 46. result_valid pulses once and op_pending ends at 0.
- Keys 7,B,9,E then E -> results -2, then -11. result_valid pulses twice.
- Keys 1,2,3,4,5 -> display_val stays 1234. Then C -> display_val=0, op_pending=0.
- rst_n pulsed low for 1 cycle in the middle of ENTER_B with a key held -> all outputs 0 immediately. The held key produces an event only after 8 more active cycles.
